// File: rtl/gpu_pkg.sv
// Constants shared by the miniGPU core blocks: core sequencing states and the
// fetcher/LSU status encodings that the scheduler observes.
package gpu_pkg;

  localparam int PC_WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;

  typedef enum logic [1:0] {
    FETCHER_IDLE     = 2'b00,
    FETCHER_FETCHING = 2'b01,
    FETCHER_FETCHED  = 2'b10
  } fetcher_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_t;

  // A lane holds up the join while its memory access is still outstanding.
  function automatic logic lsu_busy(input logic [1:0] s);
    return (s == LSU_REQUESTING) || (s == LSU_WAITING);
  endfunction

endpackage

// File: rtl/lsu_join.sv
// Combinational join across LSU lanes: any_busy is high while any active lane
// still has a memory access in flight. Lanes at or above thread_count are ignored.
module lsu_join
  import gpu_pkg::*;
#(
  parameter int THREADS = 4
) (
  input  logic [2*THREADS-1:0] lsu_state,
  input  logic [2:0]           thread_count,
  output logic                 any_busy
);

  // thread_count above THREADS naturally enables every lane.
  always_comb begin
    any_busy = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (i < int'(thread_count) && lsu_busy(lsu_state[2*i +: 2])) any_busy = 1'b1;
    end
  end

endmodule

// File: rtl/core_scheduler.sv
// Per-core instruction sequencer: walks every instruction through
// FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE in lock-step for all active lanes.
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_WIDTH          = PC_WIDTH_DEFAULT,
  parameter int WAIT_TIMEOUT      = 255,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [2:0]                            thread_count,
  input  logic [1:0]                            fetcher_state,
  input  logic [2*THREADS_PER_BLOCK-1:0]        lsu_state,
  input  logic                                  decoded_ret,
  input  logic [PC_WIDTH*THREADS_PER_BLOCK-1:0] next_pc,
  output logic [2:0]                            core_state,
  output logic [PC_WIDTH-1:0]                   current_pc,
  output logic                                  done,
  output logic                                  error,
  output logic [COUNT_WIDTH-1:0]                retired_count
);

  localparam logic [15:0] WAIT_LAST = 16'(WAIT_TIMEOUT - 1);

  core_state_t          state_q, state_d;
  logic [15:0]          wait_cnt_q;
  logic [PC_WIDTH-1:0]  pc_q;
  logic [COUNT_WIDTH-1:0] retired_q;
  logic                 error_q;
  logic                 any_busy;
  logic                 launch, retire, timeout;

  // Only lane 0 steers the shared PC; the other lanes' next_pc are not needed.
  logic unused_lanes;
  assign unused_lanes = ^next_pc[PC_WIDTH*THREADS_PER_BLOCK-1:PC_WIDTH];

  lsu_join #(.THREADS(THREADS_PER_BLOCK)) u_lsu_join (
    .lsu_state    (lsu_state),
    .thread_count (thread_count),
    .any_busy     (any_busy)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d = state_q;
    launch  = 1'b0;
    retire  = 1'b0;
    timeout = 1'b0;
    case (state_q)
      CORE_IDLE: if (start) begin
        state_d = CORE_FETCH;
        launch  = 1'b1;
      end
      CORE_FETCH:   if (fetcher_state == FETCHER_FETCHED) state_d = CORE_DECODE;
      CORE_DECODE:  state_d = CORE_REQUEST;
      CORE_REQUEST: state_d = CORE_WAIT;
      CORE_WAIT: begin
        if (!any_busy) begin
          state_d = CORE_EXECUTE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = CORE_DONE;
          timeout = 1'b1;
        end
      end
      CORE_EXECUTE: state_d = CORE_UPDATE;
      CORE_UPDATE: begin
        retire  = 1'b1;
        state_d = decoded_ret ? CORE_DONE : CORE_FETCH;
      end
      CORE_DONE:    state_d = CORE_DONE;
      default:      state_d = CORE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= CORE_IDLE;
      wait_cnt_q <= '0;
      pc_q       <= '0;
      retired_q  <= '0;
      error_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop here samples pre-edge values.
      state_q <= state_d;
      if (state_q == CORE_REQUEST)   wait_cnt_q <= '0;
      else if (state_q == CORE_WAIT) wait_cnt_q <= wait_cnt_q + 16'd1;
      if (launch) begin
        pc_q      <= '0;
        retired_q <= '0;
        error_q   <= 1'b0;
      end
      if (timeout) error_q <= 1'b1;
      if (retire) begin
        if (retired_q != '1) retired_q <= retired_q + 1'b1;
        if (!decoded_ret)    pc_q      <= next_pc[PC_WIDTH-1:0];
      end
    end
  end

  assign core_state    = state_q;
  assign current_pc    = pc_q;
  assign done          = (state_q == CORE_DONE);
  assign error         = error_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Self-checking bench for core_scheduler: a procedural phase-walking model is
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_core_scheduler;

  localparam int TO = 12;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  thread_count;
  logic [1:0]  fetcher_state;
  logic [7:0]  lsu_state;
  logic        decoded_ret = 1'b0;
  logic [31:0] next_pc = '0;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        done;
  logic        error;
  logic [15:0] retired_count;

  core_scheduler #(.WAIT_TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .thread_count  (thread_count),
    .fetcher_state (fetcher_state),
    .lsu_state     (lsu_state),
    .decoded_ret   (decoded_ret),
    .next_pc       (next_pc),
    .core_state    (core_state),
    .current_pc    (current_pc),
    .done          (done),
    .error         (error),
    .retired_count (retired_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int exp_state = 0, exp_pc = 0, exp_cnt = 0, exp_err = 0, exp_done = 0;

  function automatic bit lanes_busy();
    int n;
    n = (int'(thread_count) > 4) ? 4 : int'(thread_count);
    for (int i = 0; i < n; i++) begin
      int s;
      s = int'(lsu_state[2*i +: 2]);
      if (s == 1 || s == 2) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk or negedge reset);
  endtask

  // Walks one kernel phase by phase; returns as soon as reset is asserted.
  task automatic model_run();
    int waited;
    do begin tick(); if (!reset) return; end while (!start);
    exp_pc = 0; exp_cnt = 0; exp_err = 0;
    forever begin
      exp_state = 1;
      do begin tick(); if (!reset) return; end while (fetcher_state != 2'b10);
      exp_state = 2; tick(); if (!reset) return;
      exp_state = 3; tick(); if (!reset) return;
      exp_state = 4;
      waited = 0;
      forever begin
        tick(); if (!reset) return;
        if (!lanes_busy()) break;
        waited++;
        if (waited == TO) begin
          exp_state = 7; exp_err = 1; exp_done = 1;
          forever begin tick(); if (!reset) return; end
        end
      end
      exp_state = 5; tick(); if (!reset) return;
      exp_state = 6; tick(); if (!reset) return;
      if (exp_cnt < 65535) exp_cnt++;
      if (decoded_ret) begin
        exp_state = 7; exp_done = 1;
        forever begin tick(); if (!reset) return; end
      end
      exp_pc = int'(next_pc[7:0]);
    end
  endtask

  initial begin
    forever begin
      exp_state = 0; exp_pc = 0; exp_cnt = 0; exp_err = 0; exp_done = 0;
      wait (reset === 1'b1);
      model_run();
    end
  end

  always @(negedge clk) begin
    check("cmp_state", int'(core_state), exp_state);
    check("cmp_pc", int'(current_pc), exp_pc);
    check("cmp_retired", int'(retired_count), exp_cnt);
    check("cmp_error", int'(error), exp_err);
    check("cmp_done", int'(done), exp_done);
  end

  // ---------------- stimulus helpers ----------------
  logic       ret_en = 1'b0;
  logic [7:0] ret_pc = 8'd0;

  // Lane 0 carries pc+1; other lanes carry distinct junk to expose a wrong slice.
  initial begin
    forever begin
      @(negedge clk);
      next_pc     = {current_pc + 8'd49, current_pc + 8'd33, current_pc + 8'd17, current_pc + 8'd1};
      decoded_ret = ret_en && (current_pc == ret_pc);
    end
  end

  task automatic wait_for_state(input logic [2:0] s, input string name);
    int n = 0;
    while (core_state !== s && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(core_state), int'(s));
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // Sets up the LSU pattern for the next WAIT, then measures how long WAIT lasts.
  task automatic wait_trial(input string name, input logic [2:0] tc, input logic [7:0] busy_vec,
                            input logic [7:0] idle_vec, input int busy_n, input int exp_len);
    int len = 0;
    thread_count = tc;
    lsu_state    = busy_vec;
    wait_for_state(3'd4, {name, "_reach_wait"});
    while (core_state === 3'd4 && len < 64) begin
      len++;
      if (len == busy_n + 1) lsu_state = idle_vec;
      @(negedge clk);
    end
    check({name, "_wait_len"}, len, exp_len);
    lsu_state = 8'h00;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    reset = 1'b0; start = 1'b0; thread_count = 3'd4;
    fetcher_state = 2'b10; lsu_state = 8'h00;

    // Reset then idle with start low.
    repeat (3) @(negedge clk);
    check("rst_state", int'(core_state), 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_state", int'(core_state), 0);
    check("idle_pc", int'(current_pc), 0);

    // Fast path: six-cycle instructions back to back.
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("fast_seq", int'(core_state), (i % 6) + 1);
    end
    @(negedge clk);
    check("fast_pc", int'(current_pc), 2);
    check("fast_retired", int'(retired_count), 2);
    start = 1'b0;

    // LSU join across active and inactive lanes.
    wait_trial("join_tc4", 3'd4, 8'h20, 8'h30, 7, 8);
    check("join_exec", int'(core_state), 5);
    wait_trial("join_tc2", 3'd2, 8'h20, 8'h20, 7, 1);
    wait_trial("join_tc0", 3'd0, 8'h55, 8'h55, 7, 1);
    wait_trial("join_tc7", 3'd7, 8'h40, 8'h00, 2, 3);

    // Timeout on a stuck lane 0.
    wait_trial("timeout", 3'd4, 8'h01, 8'h01, 99, TO);
    check("to_state", int'(core_state), 7);
    check("to_error", int'(error), 1);
    check("to_done", int'(done), 1);
    check("to_retired", int'(retired_count), 6);
    check("to_pc", int'(current_pc), 6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("to_start_ignored", int'(core_state), 7);

    // RET on the third instruction.
    do_reset();
    check("rst_clears_error", int'(error), 0);
    thread_count = 3'd4; ret_pc = 8'd2; ret_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for_state(3'd7, "ret_reach_done");
    check("ret_pc", int'(current_pc), 2);
    check("ret_retired", int'(retired_count), 3);
    check("ret_done", int'(done), 1);
    check("ret_error", int'(error), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("ret_start_ignored", int'(core_state), 7);
    check("ret_pc_hold", int'(current_pc), 2);
    ret_en = 1'b0;

    // Asynchronous reset in the middle of WAIT.
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for_state(3'd6, "ar_reach_update");
    lsu_state = 8'h02;
    wait_for_state(3'd4, "ar_reach_wait");
    check("ar_pc_before", int'(current_pc), 1);
    #2 reset = 1'b0;
    #1;
    check("ar_state", int'(core_state), 0);
    check("ar_pc", int'(current_pc), 0);
    check("ar_retired", int'(retired_count), 0);
    check("ar_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    lsu_state = 8'h00;
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ar_resume_state", int'(core_state), 1);
    check("ar_resume_pc", int'(current_pc), 0);
    repeat (6) @(negedge clk);
    check("ar_resume_pc1", int'(current_pc), 1);
    check("ar_resume_retired", int'(retired_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/core_scheduler.md
Name: core_scheduler

Overview:
- Per-core instruction sequencer for the miniGPU. Drives the shared `core_state` bus that gates the ALU, LSU, fetcher, decoder and register files.
- Steps one instruction at a time through FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE for all active threads in lock-step.
- Joins on LSU completion, advances the shared PC, and signals kernel completion, or a stuck memory access via timeout.

Parameters:
- THREADS_PER_BLOCK, 4, number of thread lanes (ALU/LSU instances) in the core.
- PC_WIDTH, 8, program counter width.
- WAIT_TIMEOUT, 255, maximum cycles spent in WAIT before error abort; legal range 1..2^16-1.
- COUNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous reset, active-low (0 = reset asserted).
- start  in  1  launch pulse/level from the dispatcher; sampled only in IDLE.
- thread_count  in  3  number of active lanes, 0..THREADS_PER_BLOCK; lanes [thread_count-1:0] are active.
- fetcher_state  in  2  fetcher status: IDLE 00, FETCHING 01, FETCHED 10.
- lsu_state  in  2*THREADS_PER_BLOCK  per-lane LSU status, lane i at [2i+1:2i]: IDLE 00, REQUESTING 01, WAITING 10, DONE 11.
- decoded_ret  in  1  decoder flag: current instruction is RET.
- next_pc  in  PC_WIDTH*THREADS_PER_BLOCK  per-lane computed next PC; lane 0 slice is authoritative.
- core_state  out  3  IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
- current_pc  out  PC_WIDTH  PC of the instruction in flight.
- done  out  1  kernel finished (normal or error).
- error  out  1  sticky: WAIT timeout occurred.
- retired_count  out  COUNT_WIDTH  instructions retired since launch, saturating.

Behaviour:
- Reset (async, reset==0): core_state=IDLE, current_pc=0, done=0, error=0, retired_count=0, wait counter=0. Takes effect immediately and from any state, including mid-WAIT. Release is synchronous to clk.
- All state transitions happen on the rising edge of clk.
- IDLE:
  - start==1 → FETCH; current_pc<=0, retired_count<=0, error<=0.
  - start==0 → stay in IDLE.
- FETCH:
  - Stay while fetcher_state!=FETCHED.
  - fetcher_state==FETCHED → DECODE. A FETCHED seen in the first FETCH cycle is accepted.
- DECODE: exactly 1 cycle → REQUEST.
- REQUEST: exactly 1 cycle → WAIT. Clear the wait counter.
- WAIT:
  - Minimum 1 cycle.
  - Each cycle, any active lane with lsu_state in {REQUESTING, WAITING} → stay and increment the wait counter.
  - Otherwise → EXECUTE.
  - Inactive lanes are ignored. thread_count==0 means WAIT always exits after 1 cycle.
  - Wait counter reaching WAIT_TIMEOUT while still busy → DONE with error<=1, done<=1. The instruction does not retire.
- EXECUTE: exactly 1 cycle → UPDATE. The ALU and PC unit latch in this cycle.
- UPDATE: exactly 1 cycle. retired_count<=retired_count+1, saturating at all-ones.
  - decoded_ret==1 → DONE, done<=1; current_pc unchanged.
  - Otherwise → FETCH, current_pc<=next_pc lane-0 slice. PC wraps naturally at 2^PC_WIDTH; no check is made.
- DONE: hold; done=1. start is ignored; exit only via reset.
- Minimum latency per instruction: 6 cycles (FETCHED already present, LSUs idle). Back-to-back instructions: UPDATE→FETCH with no gap.
- start held high is harmless: it is ignored outside IDLE.
- thread_count>THREADS_PER_BLOCK is treated as THREADS_PER_BLOCK.

Decomposition:
- Shared package gpu_pkg holds:
  - the core_state encodings (CORE_IDLE..CORE_DONE);
  - the fetcher and LSU state encodings;
  - PC_WIDTH default.
  - The ALU, LSU, fetcher and this block import the same constants.
- One natural combinational sub-module, lsu_join: takes the lsu_state vector and thread_count, outputs any_busy. It is reused later by the multi-core dispatcher.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, then release with start=0 for 5 cycles → core_state=000, pc=0, done=0, error=0, retired_count=0 throughout.
- Fast path: start=1, fetcher_state=10 constant, all LSU=00, next_pc=pc+1, decoded_ret=0 → states cycle 001,010,011,100,101,110 every 6 cycles; pc 0→1→2; retired_count=2 after 12 cycles.
- LSU join, thread_count=4: lane 2 lsu_state=10 for 7 WAIT cycles then 11 → WAIT lasts 8 cycles, then EXECUTE. The same stimulus with thread_count=2 → WAIT lasts 1 cycle.
- RET: third instruction has decoded_ret=1 → DONE after UPDATE; done=1, pc=2, retired_count=3. A start pulse in DONE → no change.
- Timeout: WAIT_TIMEOUT=4, lane 0 stuck at 01 → after 4 WAIT cycles core_state=111, error=1, done=1, retired_count unchanged.
- Async reset mid-WAIT: drop reset asynchronously (not on a clk edge) → outputs return to reset values immediately. After release and start=1, fetch resumes at pc=0.
